// File: rtl/softex_tcdm_responder_if.sv
// TCDM request/response bundle between an initiator (master) and a memory target (slave).
// Latency: none, wires only.
// Backpressure: req/gnt on the request side, r_valid/r_ready on the response side.
interface softex_tcdm_responder_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1
);

  // Request channel
  logic                      req;
  logic                      gnt;
  logic [ADDR_WIDTH-1:0]     add;
  logic                      wen;
  logic [DATA_WIDTH/8-1:0]   be;
  logic [DATA_WIDTH-1:0]     data;
  logic [ID_WIDTH-1:0]       id;

  // Response channel
  logic                      r_valid;
  logic                      r_ready;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [ID_WIDTH-1:0]       r_id;
  logic                      r_opc;

  modport master (
    output req, add, wen, be, data, id, r_ready,
    input  gnt, r_valid, r_data, r_id, r_opc
  );

  modport slave (
    input  req, add, wen, be, data, id, r_ready,
    output gnt, r_valid, r_data, r_id, r_opc
  );

endinterface

// File: rtl/softex_tcdm_responder.sv
// TCDM target: word-addressed byte-enabled memory answering every granted request in order.
// Latency: grant to r_valid is RD_LATENCY+1 cycles (shift pipeline plus one FIFO register stage).
// Backpressure: credits cover pipeline plus FIFO, so gnt drops when r_ready stalls; optional
// random bank-contention stalls on gnt when SOFTEX_TCDM_RESPONDER_STALL_EN is defined.
module softex_tcdm_responder #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned N_WORDS    = 1024,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
`ifdef SOFTEX_TCDM_RESPONDER_STALL_EN
  input  logic                   stall_en_i,
`endif
  softex_tcdm_responder_if.slave tcdm,
  output logic                   busy_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W   = $clog2(BE_WIDTH);
  localparam int unsigned IDX_W    = $clog2(N_WORDS);
  localparam int unsigned CRD_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic                  opc;
  } resp_t;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [N_WORDS];
  logic [IDX_W-1:0]      word_idx;
  logic [CRD_W-1:0]      crd_q;
  logic                  stall;
  logic                  hs;
  logic                  pop;
  logic                  unused_add;

  // Offset bits select bytes inside a word, upper bits alias onto the array.
  assign word_idx   = tcdm.add[OFFS_W +: IDX_W];
  assign unused_add = ^tcdm.add;

`ifdef SOFTEX_TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Free-running contention pattern, independent of traffic and clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign stall = stall_en_i && (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Grant is held low in reset and in the clear cycle so nothing slips past a flush.
  assign tcdm.gnt = rst_ni && !clear_i && !stall && tcdm.req && (crd_q != '0);
  assign hs       = tcdm.req && tcdm.gnt;

  // Byte-enabled write at the edge that closes the handshake; contents survive clear.
  always_ff @(posedge clk_i) begin
    if (hs && !tcdm.wen) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (tcdm.be[b]) begin
          mem_q[word_idx][b*8 +: 8] <= tcdm.data[b*8 +: 8];
        end
      end
    end
  end

  resp_t resp_in;

  // Response payload formed in the handshake cycle; writes return zero data.
  always_comb begin
    resp_in      = '0;
    resp_in.id   = tcdm.id;
    resp_in.opc  = !tcdm.wen;
    resp_in.data = tcdm.wen ? mem_q[word_idx] : '0;
  end

  // ---------------------------------------------------------------------------
  // Fixed-latency response pipeline
  // ---------------------------------------------------------------------------
  logic [RD_LATENCY-1:0] pipe_vld_q;
  resp_t                 pipe_dat_q [RD_LATENCY];
  logic                  push;

  // Valid bits shift every cycle; a clear drops everything in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_vld_q <= '0;
    end else if (clear_i) begin
      pipe_vld_q <= '0;
    end else begin
      pipe_vld_q[0] <= hs;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
      end
    end
  end

  // Payload shifts alongside the valid bits; qualified by them, so no reset needed.
  always_ff @(posedge clk_i) begin
    pipe_dat_q[0] <= resp_in;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_dat_q[i] <= pipe_dat_q[i-1];
    end
  end

  assign push = pipe_vld_q[RD_LATENCY-1];

  // ---------------------------------------------------------------------------
  // Response FIFO (first-word fall-through from registered storage)
  // ---------------------------------------------------------------------------
  resp_t            fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CRD_W-1:0] cnt_q;
  logic             fifo_empty;
  logic             fifo_full;
  resp_t            head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CRD_MAX);
  assign pop        = tcdm.r_valid && tcdm.r_ready;

  // Pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CRD_W'(1);
        2'b01:   cnt_q <= cnt_q - CRD_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; entries are only observed through the occupancy count.
  always_ff @(posedge clk_i) begin
    if (push && !clear_i) begin
      fifo_q[wr_ptr_q] <= pipe_dat_q[RD_LATENCY-1];
    end
  end

  assign head         = fifo_q[rd_ptr_q];
  assign tcdm.r_valid = !fifo_empty;
  // Outputs read as zero whenever nothing is presented, including straight out of reset.
  assign tcdm.r_data  = tcdm.r_valid ? head.data : '0;
  assign tcdm.r_id    = tcdm.r_valid ? head.id   : '0;
  assign tcdm.r_opc   = tcdm.r_valid && head.opc;

  // ---------------------------------------------------------------------------
  // Credits: free FIFO slots minus responses still travelling the pipeline
  // ---------------------------------------------------------------------------
  // Grant consumes a credit, accepted response returns one; clear restores all.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crd_q <= CRD_MAX;
    end else if (clear_i) begin
      crd_q <= CRD_MAX;
    end else begin
      case ({hs, pop})
        2'b10:   crd_q <= crd_q - CRD_W'(1);
        2'b01:   crd_q <= crd_q + CRD_W'(1);
        default: crd_q <= crd_q;
      endcase
    end
  end

  assign busy_o = (crd_q != CRD_MAX);

  // Credits make these unreachable; a hit means the accounting is broken.
  a_fifo_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full && !pop && !clear_i));
  a_crd_upper : assert property (@(posedge clk_i) disable iff (!rst_ni)
    crd_q <= CRD_MAX);
  a_crd_lower : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(hs && crd_q == '0));

endmodule

// File: tb/tb_softex_tcdm_responder.sv
// Self-checking bench for softex_tcdm_responder with a reference memory and response scoreboard.
// Latency: checks grant-to-valid of RD_LATENCY+1 when the response side is not stalled.
// Backpressure: exercises r_ready stalls, credit exhaustion, clear and async reset mid-flight.
module tb_softex_tcdm_responder;

  localparam int DW  = 256;
  localparam int AW  = 32;
  localparam int IW  = 1;
  localparam int NW  = 1024;
  localparam int LAT = 1;
  localparam int FD  = 4;
  localparam int BW  = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  softex_tcdm_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) tcdm ();

  softex_tcdm_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW),
    .N_WORDS(NW), .RD_LATENCY(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
`ifdef SOFTEX_TCDM_RESPONDER_STALL_EN
    .stall_en_i (1'b0),
`endif
    .tcdm    (tcdm),
    .busy_o  (busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          opc;
    int            cyc;
  } exp_t;

  exp_t          sb_q [$];
  logic [DW-1:0] mem_m [NW];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            grants = 0;
  int            stalls = 0;
  int            vld_cnt = 0;
  logic          thr_win = 1'b0;
  logic          lat_chk = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / BW) % NW);
  endfunction

  // Monitor at mid-cycle: record handshakes into the model, score accepted responses.
  always @(negedge clk) begin
    exp_t e;
    exp_t r;
    int   w;
    cyc++;
    if (rst_n) begin
      if (clear) begin
        sb_q.delete();
      end else begin
        if (thr_win && tcdm.req && !tcdm.gnt) stalls++;
        if (thr_win && tcdm.r_valid) vld_cnt++;
        if (tcdm.req && tcdm.gnt) begin
          grants++;
          w     = widx(tcdm.add);
          e.id  = tcdm.id;
          e.cyc = cyc;
          if (tcdm.wen) begin
            e.data = mem_m[w];
            e.opc  = 1'b0;
          end else begin
            e.data = '0;
            e.opc  = 1'b1;
            for (int b = 0; b < BW; b++) begin
              if (tcdm.be[b]) mem_m[w][b*8 +: 8] = tcdm.data[b*8 +: 8];
            end
          end
          sb_q.push_back(e);
        end
        if (tcdm.r_valid && tcdm.r_ready) begin
          chk("rsp_expected", DW'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            r = sb_q.pop_front();
            chk("r_data", tcdm.r_data, r.data);
            chk("r_id",   DW'(tcdm.r_id), DW'(r.id));
            chk("r_opc",  DW'(tcdm.r_opc), DW'(r.opc));
            if (lat_chk) chk("latency", DW'(cyc - r.cyc), LAT + 1);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tcdm.req = 1'b0;
  endtask

  // Present one request and hold it until granted (bounded).
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [BW-1:0] be,
                       input logic [DW-1:0] d, input logic [IW-1:0] id);
    logic g;
    int   n;
    n = 0;
    tcdm.req  = 1'b1;
    tcdm.wen  = w;
    tcdm.add  = a;
    tcdm.be   = be;
    tcdm.data = d;
    tcdm.id   = id;
    forever begin
      #3;
      g = tcdm.gnt;
      tick();
      if (g) break;
      n++;
      if (n > 200) begin
        chk("gnt_wait", DW'(g), 1);
        break;
      end
    end
  endtask

  initial begin
    #100000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0]   p;
    logic [DW-1:0] d;
    int            g0;

    tcdm.req = 1'b0; tcdm.wen = 1'b1; tcdm.add = '0; tcdm.be = '0;
    tcdm.data = '0; tcdm.id = '0; tcdm.r_ready = 1'b0;

    // Reset state, with a request pending to show gnt is held low.
    repeat (2) @(posedge clk);
    #1 tcdm.req = 1'b1;
    #2;
    chk("rst_gnt",     DW'(tcdm.gnt), 0);
    chk("rst_r_valid", DW'(tcdm.r_valid), 0);
    chk("rst_r_data",  tcdm.r_data, 0);
    chk("rst_r_id",    DW'(tcdm.r_id), 0);
    chk("rst_r_opc",   DW'(tcdm.r_opc), 0);
    chk("rst_busy",    DW'(busy), 0);
    tcdm.req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Write then read back, in order, at minimum latency.
    tcdm.r_ready = 1'b1;
    lat_chk = 1'b1;
    d = {BW{8'hA5}};
    issue(1'b0, 32'h40, '1, d, 1'b1);
    issue(1'b1, 32'h40, '0, '0, 1'b0);
    idle();
    repeat (5) tick();

    // Partial write over a full word.
    d = {BW{8'h11}};
    issue(1'b0, 32'h00, '1, d, 1'b0);
    d = {BW{8'hFF}};
    issue(1'b0, 32'h00, BW'(32'h0000_000F), d, 1'b1);
    issue(1'b1, 32'h00, '0, '0, 1'b1);
    idle();
    repeat (5) tick();

    // Upper address bits alias onto the array.
    d = {8{32'hC0DE_0020}};
    issue(1'b0, AW'(NW * BW + 32'h20), '1, d, 1'b0);
    issue(1'b1, 32'h20, '0, '0, 1'b1);
    idle();
    repeat (5) tick();

    // Fill words 0..31, then stream them back with no bubbles.
    for (int i = 0; i < 32; i++) begin
      p = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
      d = {8{p}};
      issue(1'b0, AW'(i * BW), '1, d, IW'(i % 2));
    end
    idle();
    repeat (4) tick();
    thr_win = 1'b1;
    for (int i = 0; i < 32; i++) issue(1'b1, AW'(i * BW), '0, '0, IW'(i % 2));
    idle();
    repeat (4) tick();
    thr_win = 1'b0;
    chk("thr_stalls", DW'(stalls), 0);
    chk("thr_valids", DW'(vld_cnt), 32);

    // Backpressure: six reads against a four-entry FIFO with r_ready low.
    tcdm.r_ready = 1'b0;
    lat_chk = 1'b0;
    g0 = grants;
    fork
      begin
        for (int i = 0; i < 6; i++) issue(1'b1, AW'(i * BW), '0, '0, IW'(i % 2));
        idle();
      end
      begin
        repeat (10) tick();
        chk("bp_grants",  DW'(grants - g0), FD);
        chk("bp_gnt_low", DW'(tcdm.gnt), 0);
        chk("bp_busy",    DW'(busy), 1);
        chk("bp_pending", DW'(sb_q.size()), FD);
        if (sb_q.size() > 0) begin
          chk("bp_head_data", tcdm.r_data, sb_q[0].data);
          chk("bp_head_id",   DW'(tcdm.r_id), DW'(sb_q[0].id));
        end
        repeat (3) tick();
        if (sb_q.size() > 0) begin
          chk("bp_stable_data", tcdm.r_data, sb_q[0].data);
          chk("bp_stable_opc",  DW'(tcdm.r_opc), DW'(sb_q[0].opc));
        end
        tcdm.r_ready = 1'b1;
      end
    join
    repeat (10) tick();
    chk("bp_total", DW'(grants - g0), 6);

    // Clear with three reads outstanding and a write waiting for grant.
    tcdm.r_ready = 1'b0;
    for (int i = 10; i < 13; i++) issue(1'b1, AW'(i * BW), '0, '0, 1'b1);
    tcdm.req = 1'b1; tcdm.wen = 1'b0; tcdm.add = AW'(10 * BW);
    tcdm.be = '1; tcdm.data = '1;
    clear = 1'b1;
    #3;
    chk("clr_gnt",      DW'(tcdm.gnt), 0);
    chk("clr_busy_pre", DW'(busy), 1);
    tick();
    clear = 1'b0;
    tcdm.req = 1'b0;
    chk("clr_r_valid", DW'(tcdm.r_valid), 0);
    chk("clr_busy",    DW'(busy), 0);
    tcdm.r_ready = 1'b1;
    lat_chk = 1'b1;
    issue(1'b1, AW'(10 * BW), '0, '0, 1'b0);
    idle();
    repeat (5) tick();
    chk("sb_drained", DW'(sb_q.size()), 0);

    // Async reset in the middle of a cycle with responses pending.
    tcdm.r_ready = 1'b0;
    lat_chk = 1'b0;
    issue(1'b1, AW'(3 * BW), '0, '0, 1'b1);
    issue(1'b1, AW'(4 * BW), '0, '0, 1'b1);
    tcdm.req = 1'b1;
    @(posedge clk);
    #3;
    chk("pre_rst_valid", DW'(tcdm.r_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_r_valid", DW'(tcdm.r_valid), 0);
    chk("arst_gnt",     DW'(tcdm.gnt), 0);
    chk("arst_busy",    DW'(busy), 0);
    chk("arst_r_data",  tcdm.r_data, 0);
    chk("arst_r_id",    DW'(tcdm.r_id), 0);
    chk("arst_r_opc",   DW'(tcdm.r_opc), 0);
    sb_q.delete();
    tcdm.req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/softex_tcdm_responder.md
Name: softex_tcdm_responder

Overview:
- HCI/TCDM target-side responder: the memory end of the protocol driven by the softex streamer's TCDM initiator port.
- Holds a word-addressed memory array and accepts one request per cycle (req/gnt).
- Returns in-order responses (r_valid/r_ready) after a fixed pipeline latency, buffered in a credit-protected response FIFO.
- Used as the TCDM endpoint in softex testbenches and as a local scratchpad in standalone integrations.

Parameters:
- DATA_WIDTH, 256: word width in bits; multiple of 8.
- ADDR_WIDTH, 32: request address width (byte address).
- ID_WIDTH, 1: request/response ID width; ID_WIDTH ≥ 1.
- N_WORDS, 1024: array depth in words; power of two.
- RD_LATENCY, 1: cycles from grant to response entering the FIFO; 1..4.
- FIFO_DEPTH, 4: response FIFO entries; ≥ RD_LATENCY+1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear of pipeline/FIFO/credits (memory contents kept)
- req_i  in  1  request valid
- gnt_o  out  1  request grant
- add_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1=read, 0=write (HCI convention)
- be_i  in  DATA_WIDTH/8  byte enables (writes)
- data_i  in  DATA_WIDTH  write data
- id_i  in  ID_WIDTH  request ID
- r_valid_o  out  1  response valid
- r_ready_i  in  1  response accepted
- r_data_o  out  DATA_WIDTH  read data (0 for writes)
- r_id_o  out  ID_WIDTH  echoed ID
- r_opc_o  out  1  1 = response to a write
- busy_o  out  1  any transaction in flight or buffered

Behaviour:
- Reset (rst_ni low, async): gnt_o=0, r_valid_o=0, r_data_o=0, r_id_o=0, r_opc_o=0, busy_o=0; credits=FIFO_DEPTH; pipeline and FIFO empty. Memory contents undefined.
- Word index = add_i[log2(DATA_WIDTH/8) +: log2(N_WORDS)]. Lower offset bits are ignored; upper bits alias (wrap modulo N_WORDS).
- Credit counter tracks free FIFO slots minus pipeline occupancy.
  - gnt_o = req_i && credits>0 (combinational).
  - Handshake occurs when req_i && gnt_o.
  - Decrement on handshake; increment on r_valid_o && r_ready_i; both in one cycle leaves credits unchanged.
  - Credits never exceed FIFO_DEPTH and never go below 0.
- Write handshake: bytes with be_i=1 are written at the clock edge ending the handshake cycle; other bytes are kept.
- Read handshake: the array is sampled in the handshake cycle (read-old-data is impossible since there is only one request per cycle).
  - A read at cycle N+1 returns data written at cycle N.
- Every handshake (read or write) produces exactly one response.
  - The response carries {data, id, opc} and enters a RD_LATENCY-deep shift pipeline.
  - It is pushed into the FIFO RD_LATENCY cycles after the handshake.
- Response FIFO: first-word fall-through.
  - r_valid_o = !empty; outputs driven from the head.
  - Pop on r_valid_o && r_ready_i.
  - Push and pop in the same cycle are allowed when full or when empty with a bypass-free path. Minimum grant→r_valid latency = RD_LATENCY+1 cycles via the FIFO register stage.
  - Credits guarantee the FIFO never overflows; overflow is an assertion failure.
- Ordering: responses are strictly in grant order, with no reordering across IDs.
- r_valid_o held with r_ready_i=0: r_data_o, r_id_o and r_opc_o stay stable until accepted.
- clear_i:
  - Drops pipeline and FIFO contents and restores credits=FIFO_DEPTH.
  - gnt_o is forced 0 in the clear cycle.
  - Writes granted before the clear remain committed.
- busy_o = (credits != FIFO_DEPTH).

Optional Feature:
- Macro: SOFTEX_TCDM_RESPONDER_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, reset seed 16'hACE1) advances every cycle.
  - gnt_o is additionally masked to 0 whenever lfsr[1:0]==2'b00, emulating bank contention.
  - Input port stall_en_i (1 bit) gates the mask; with stall_en_i=0 behaviour equals the undefined build.
- Undefined: no LFSR, no stall_en_i port; gnt_o purely credit-based.

Test Plan:
- Write then read: write addr 0x40, be all ones, data 0xA5 pattern, id 1; read 0x40, id 0 → write response r_opc=1, r_id=1 at RD_LATENCY+1; read response r_data=0xA5 pattern, r_id=0, in order.
- Partial write: write 0x00 full 0x11 bytes, then be=0x0000_000F with 0xFF bytes, read → bytes 0-3 = 0xFF, rest 0x11.
- Backpressure: r_ready_i=0 with 6 back-to-back reads (FIFO_DEPTH=4) → exactly 4 grants, gnt_o=0 afterwards, outputs stable; raise r_ready_i → remaining 2 granted, 6 responses in order.
- Full throughput: r_ready_i=1, continuous reads of 0..31 → gnt_o=1 every cycle, one r_valid per cycle after RD_LATENCY+1 fill.
- Aliasing: write addr N_WORDS*DATA_WIDTH/8 + 0x20, read 0x20 → same data.
- Clear/reset mid-flight: 3 reads outstanding, pulse clear_i → r_valid_o=0 next cycle, busy_o=0, credits=FIFO_DEPTH; async rst_ni low mid-cycle → all outputs 0 immediately.
